// File: rtl/cmd_dispatcher_if.sv
// Byte-in / command-out bundle of the UART command dispatcher.
// The master modport is the dispatcher side; the slave modport is the
// environment (UART receiver plus command backend).
interface cmd_dispatcher_if #(
    parameter int unsigned NUM_CMDS      = 4,
    parameter int unsigned PAYLOAD_BYTES = 8
);
    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic [NUM_CMDS-1:0]        cmd_valid;
    logic                       cmd_ready;
    logic [8*PAYLOAD_BYTES-1:0] cmd_payload;
    logic [7:0]                 cmd_opcode;
    logic                       busy;
    logic                       err_opcode;
    logic                       err_overrun;
    logic                       err_timeout;

    modport master (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_payload, cmd_opcode, busy,
        output err_opcode, err_overrun, err_timeout
    );

    modport slave (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_payload, cmd_opcode, busy,
        input  err_opcode, err_overrun, err_timeout
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// Assembles UART bytes into command frames: one opcode byte followed by
// PAYLOAD_BYTES payload bytes, then presents the frame on a one-hot
// cmd_valid until the backend accepts it.
// Optional feature: define CMD_DISPATCHER_TIMEOUT_EN to abort a partial frame
// after TIMEOUT_CYCLES clocks without a byte.
module cmd_dispatcher #(
    parameter int unsigned NUM_CMDS       = 4,
    parameter int unsigned PAYLOAD_BYTES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input logic              clk,
    input logic              rst_n,
    cmd_dispatcher_if.master bus
);
    localparam int unsigned PayloadW = 8 * PAYLOAD_BYTES;
    localparam int unsigned CntW     = $clog2(PAYLOAD_BYTES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(PAYLOAD_BYTES - 1);

    if (NUM_CMDS < 2 || NUM_CMDS > 16) begin : g_bad_num_cmds
        $error("NUM_CMDS must be in 2..16");
    end
    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 32) begin : g_bad_payload_bytes
        $error("PAYLOAD_BYTES must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StCollect  = 2'd1,
        StDispatch = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [PayloadW-1:0] payload_q, payload_d, payload_shift;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_opcode_q, err_opcode_d;
    logic                err_overrun_q, err_overrun_d;
    logic                opcode_legal;
    logic                tmo_expire;

    assign opcode_legal = bus.rx_data < 8'(NUM_CMDS);

    // First received byte ends up in the most significant byte.
    if (PAYLOAD_BYTES > 1) begin : g_shift
        assign payload_shift = {payload_q[PayloadW-9:0], bus.rx_data};
    end else begin : g_no_shift
        assign payload_shift = bus.rx_data;
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        payload_d     = payload_q;
        cnt_d         = cnt_q;
        err_opcode_d  = 1'b0;
        err_overrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    if (opcode_legal) begin
                        opcode_d = bus.rx_data;
                        cnt_d    = '0;
                        state_d  = StCollect;
                    end else begin
                        err_opcode_d = 1'b1;
                    end
                end
            end
            StCollect: begin
                // Expiry wins over a byte arriving in the same cycle.
                if (tmo_expire) begin
                    payload_d = '0;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (bus.rx_valid) begin
                    payload_d = payload_shift;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_d = StDispatch;
                    end
                end
            end
            StDispatch: begin
                if (bus.cmd_ready) begin
                    state_d = StIdle;
                    // A byte in the retire cycle starts the next frame.
                    if (bus.rx_valid) begin
                        if (opcode_legal) begin
                            opcode_d = bus.rx_data;
                            cnt_d    = '0;
                            state_d  = StCollect;
                        end else begin
                            err_opcode_d = 1'b1;
                        end
                    end
                end else if (bus.rx_valid) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            opcode_q      <= '0;
            payload_q     <= '0;
            cnt_q         <= '0;
            err_opcode_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            payload_q     <= payload_d;
            cnt_q         <= cnt_d;
            err_opcode_q  <= err_opcode_d;
            err_overrun_q <= err_overrun_d;
        end
    end

`ifdef CMD_DISPATCHER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_timeout_q;

    assign tmo_expire = (state_q == StCollect) && (tmo_q == TmoLast);

    // Count idle COLLECT cycles; a byte, entry or exit restarts from zero.
    always_comb begin
        tmo_d = '0;
        if (state_q == StCollect && state_d == StCollect && !bus.rx_valid) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter and its error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            err_timeout_q <= tmo_expire;
        end
    end

    assign bus.err_timeout = err_timeout_q;
`else
    // COLLECT waits indefinitely for the rest of the frame.
    assign tmo_expire      = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.cmd_valid   = (state_q == StDispatch) ? (NUM_CMDS'(1) << opcode_q) : '0;
    assign bus.cmd_payload = payload_q;
    assign bus.cmd_opcode  = opcode_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.err_opcode  = err_opcode_q;
    assign bus.err_overrun = err_overrun_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: directed frames followed by random
// byte/ready/reset traffic, compared every cycle against a frame-level model.
module tb_cmd_dispatcher;
    localparam int unsigned NumCmds       = 4;
    localparam int unsigned PayloadBytes  = 8;
    localparam int unsigned TimeoutCycles = 16;
`ifdef CMD_DISPATCHER_TIMEOUT_EN
    localparam bit TmoEn = 1'b1;
`else
    localparam bit TmoEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cmd_dispatcher_if #(.NUM_CMDS(NumCmds), .PAYLOAD_BYTES(PayloadBytes)) bus ();

    cmd_dispatcher #(
        .NUM_CMDS      (NumCmds),
        .PAYLOAD_BYTES (PayloadBytes),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model.
    bit           m_collecting, m_pending, m_payload_zero;
    bit           m_err_op, m_err_ov, m_err_to;
    int unsigned  m_opcode, m_gap;
    byte unsigned m_bytes[$];
    logic [63:0]  m_payload;

    function automatic logic [63:0] pack_frame();
        logic [63:0] p = '0;
        foreach (m_bytes[i]) p = p * 256 + 64'(m_bytes[i]);
        return p;
    endfunction

    function automatic void model_start(input byte unsigned rd);
        if (rd < NumCmds) begin
            m_opcode     = rd;
            m_collecting = 1'b1;
            m_gap        = 0;
            m_bytes.delete();
        end else begin
            m_err_op = 1'b1;
        end
    endfunction

    function automatic void model_step(input bit rstn, input bit rv, input byte unsigned rd,
                                       input bit rdy);
        m_err_op = 1'b0;
        m_err_ov = 1'b0;
        m_err_to = 1'b0;
        if (!rstn) begin
            m_collecting   = 1'b0;
            m_pending      = 1'b0;
            m_opcode       = 0;
            m_gap          = 0;
            m_payload_zero = 1'b1;
            m_bytes.delete();
        end else if (m_pending) begin
            if (rdy) begin
                m_pending = 1'b0;
                if (rv) model_start(rd);
            end else if (rv) begin
                m_err_ov = 1'b1;
            end
        end else if (m_collecting) begin
            if (TmoEn && m_gap + 1 == TimeoutCycles) begin
                m_err_to       = 1'b1;
                m_collecting   = 1'b0;
                m_payload_zero = 1'b1;
                m_bytes.delete();
            end else if (rv) begin
                m_bytes.push_back(rd);
                m_payload_zero = 1'b0;
                m_gap          = 0;
                if (m_bytes.size() == PayloadBytes) begin
                    m_collecting = 1'b0;
                    m_pending    = 1'b1;
                    m_payload    = pack_frame();
                end
            end else begin
                m_gap++;
            end
        end else if (rv) begin
            model_start(rd);
        end
    endfunction

    task automatic compare_all();
        check_eq("cmd_valid", 64'(bus.cmd_valid), m_pending ? (64'd1 << m_opcode) : 64'd0);
        check_eq("cmd_opcode", 64'(bus.cmd_opcode), 64'(m_opcode));
        check_eq("busy", 64'(bus.busy), 64'(m_collecting || m_pending));
        check_eq("err_opcode", 64'(bus.err_opcode), 64'(m_err_op));
        check_eq("err_overrun", 64'(bus.err_overrun), 64'(m_err_ov));
        check_eq("err_timeout", 64'(bus.err_timeout), 64'(m_err_to));
        if (m_pending || m_payload_zero) begin
            check_eq("cmd_payload", bus.cmd_payload, m_pending ? m_payload : 64'd0);
        end
    endtask

    // Drive one cycle of inputs, then check right after the sampling edge.
    task automatic step(input bit rstn, input bit rv, input byte unsigned rd, input bit rdy);
        @(negedge clk);
        rst_n         = rstn;
        bus.rx_valid  = rv;
        bus.rx_data   = rd;
        bus.cmd_ready = rdy;
        model_step(rstn, rv, rd, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input byte unsigned b);
        step(1'b1, 1'b1, b, 1'b0);
    endtask

    task automatic send_frame(input byte unsigned op, input logic [63:0] data);
        send(op);
        for (int i = 0; i < 8; i++) send(data[63-8*i -: 8]);
    endtask

    int unsigned ov_cnt;

    initial begin
        rst_n         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        check_eq("rst_payload", bus.cmd_payload, 64'd0);
        idle(2);

        // Reference frame: opcode 2.
        send_frame(8'h02, 64'h0000002A_000001F4);
        check_eq("ref_valid", 64'(bus.cmd_valid), 64'h4);
        check_eq("ref_payload", bus.cmd_payload, 64'h0000002A_000001F4);
        check_eq("ref_opcode", 64'(bus.cmd_opcode), 64'h2);

        // Backpressure for 20 cycles with one dropped byte.
        ov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, i == 5, 8'h55, 1'b0);
            ov_cnt += 32'(bus.err_overrun);
        end
        check_eq("ovr_pulses", 64'(ov_cnt), 64'd1);
        check_eq("hold_payload", bus.cmd_payload, 64'h0000002A_000001F4);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("retire_valid", 64'(bus.cmd_valid), 64'd0);
        check_eq("retire_busy", 64'(bus.busy), 64'd0);

        // Illegal opcode, then a legal frame for opcode 3.
        send(8'h07);
        check_eq("badop_pulse", 64'(bus.err_opcode), 64'd1);
        check_eq("badop_busy", 64'(bus.busy), 64'd0);
        idle(1);
        check_eq("badop_single", 64'(bus.err_opcode), 64'd0);
        send_frame(8'h03, 64'h1122334455667788);
        check_eq("op3_valid", 64'(bus.cmd_valid), 64'h8);
        check_eq("op3_payload", bus.cmd_payload, 64'h1122334455667788);
        idle(2);

        // Retire and start a new frame in the same cycle.
        step(1'b1, 1'b1, 8'h01, 1'b1);
        check_eq("b2b_opcode", 64'(bus.cmd_opcode), 64'h1);
        check_eq("b2b_busy", 64'(bus.busy), 64'd1);
        check_eq("b2b_overrun", 64'(bus.err_overrun), 64'd0);
        for (int i = 0; i < 8; i++) send(8'(8'hA0 + i));
        check_eq("b2b_valid", 64'(bus.cmd_valid), 64'h2);
        check_eq("b2b_payload", bus.cmd_payload, 64'hA0A1A2A3A4A5A6A7);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Partial frame then silence.
        send(8'h00);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        idle(TimeoutCycles - 1);
        check_eq("tmo_early", 64'(bus.err_timeout), 64'd0);
        idle(1);
        check_eq("tmo_pulse", 64'(bus.err_timeout), 64'(TmoEn));
        check_eq("tmo_busy", 64'(bus.busy), 64'(!TmoEn));
        idle(3);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset after the fifth payload byte, then a clean frame.
        send(8'h01);
        for (int i = 0; i < 5; i++) send(8'(8'h30 + i));
        step(1'b0, 1'b1, 8'h02, 1'b1);
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_payload", bus.cmd_payload, 64'd0);
        send_frame(8'h03, 64'hDEADBEEF_CAFEF00D);
        check_eq("post_rst_valid", 64'(bus.cmd_valid), 64'h8);
        check_eq("post_rst_payload", bus.cmd_payload, 64'hDEADBEEF_CAFEF00D);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Random traffic: dense phase, then sparse phase to exercise gaps.
        for (int i = 0; i < 6000; i++) begin
            bit           rstn, rv, rdy;
            byte unsigned rd;
            int unsigned  rate;
            rate = (i < 3500) ? 40 : 7;
            rstn = ($urandom_range(399) != 0);
            rv   = ($urandom_range(99) < rate);
            rdy  = ($urandom_range(99) < 25);
            rd   = ($urandom_range(3) != 0) ? 8'($urandom_range(NumCmds - 1))
                                            : 8'($urandom_range(255));
            step(rstn, rv, rd, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
